// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP word, HALT opcode,
// FSM state encoding and a halt-decode helper.
package fetch_unit_pkg;

    localparam logic [15:0] NOP_INSTR_C = 16'h0800;
    localparam logic [4:0]  HALT_OPC_C  = 5'b00000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[15:11] == HALT_OPC_C);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface fetch_unit_if;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        imem_err;

    modport master (
        output imem_addr, imem_rd,
        input  imem_stall, imem_done, imem_data, imem_err
    );

    modport slave (
        input  imem_addr, imem_rd,
        output imem_stall, imem_done, imem_data, imem_err
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word while decode/memory stall.
// Clear wins over load so a redirect always invalidates the entry.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [15:0] instr_d,
    input  logic        err_d,
    output logic [15:0] instr_q,
    output logic        err_q,
    output logic        valid_q
);

    // Entry register: clear has priority, then load, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 16'h0000;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            instr_q <= 16'h0000;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_d;
            err_q   <= err_d;
            valid_q <= 1'b1;
        end else begin
            instr_q <= instr_q;
            err_q   <= err_q;
            valid_q <= valid_q;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single outstanding reads to a
// multi-cycle instruction memory and presents instructions to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_d,
    input  logic                stall_m,
    input  logic                branch_taken,
    input  logic [15:0]         branch_target,
    fetch_unit_if.master        imem,
    output logic [15:0]         instr_f,
    output logic [15:0]         pc_f,
    output logic                stall_f,
    output logic                err_instr_mem
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         drop_q, drop_d;

    logic         buf_load_s, buf_clear_s;
    logic [15:0]  buf_instr_s;
    logic         buf_err_s, buf_valid_s;

    logic         word_vld_s;
    logic [15:0]  word_s;
    logic         word_err_s;
    logic         rd_s;
    logic         deliver_s;
    logic         consume_s;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load_s),
        .clear_i (buf_clear_s),
        .instr_d (word_s),
        .err_d   (word_err_s),
        .instr_q (buf_instr_s),
        .err_q   (buf_err_s),
        .valid_q (buf_valid_s)
    );

    assign consume_s = ~stall_d & ~stall_m;

    // Next-state, PC, drop flag and skid-buffer control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        buf_load_s  = 1'b0;
        buf_clear_s = 1'b0;
        word_vld_s  = 1'b0;
        word_s      = buf_instr_s;
        word_err_s  = buf_err_s;
        rd_s        = 1'b0;

        case (state_q)
            ST_REQ: begin
                rd_s = 1'b1;
                if (!imem.imem_stall && imem.imem_done) begin
                    word_vld_s = 1'b1;
                    word_s     = imem.imem_data;
                    word_err_s = imem.imem_err;
                end else if (!imem.imem_stall) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem.imem_done && drop_q) begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end else if (imem.imem_done) begin
                    word_vld_s = 1'b1;
                    word_s     = imem.imem_data;
                    word_err_s = imem.imem_err;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                word_vld_s = buf_valid_s;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (word_vld_s && consume_s) begin
            pc_d        = pc_q + 16'd2;
            buf_clear_s = 1'b1;
            state_d     = (is_halt(word_s) || word_err_s) ? ST_HALT : ST_REQ;
        end else if (word_vld_s) begin
            buf_load_s = 1'b1;
            state_d    = ST_HOLD;
        end else begin
            buf_load_s = 1'b0;
        end

        // A read accepted or still in flight at redirect time must be drained and dropped.
        if (branch_taken) begin
            pc_d        = branch_target;
            buf_clear_s = 1'b1;
            buf_load_s  = 1'b0;
            if ((state_q == ST_WAIT && !imem.imem_done) ||
                (state_q == ST_REQ && !imem.imem_stall && !imem.imem_done)) begin
                drop_d  = 1'b1;
                state_d = ST_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = ST_REQ;
            end
        end else begin
            drop_d = drop_d;
        end
    end

    // State, PC and drop-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    assign deliver_s      = word_vld_s & ~branch_taken & ~rst;
    assign imem.imem_addr = pc_q;
    assign imem.imem_rd   = rd_s & ~rst;
    assign instr_f        = deliver_s ? word_s : NOP_INSTR;
    assign stall_f        = ~deliver_s;
    assign err_instr_mem  = deliver_s & word_err_s;
    assign pc_f           = pc_q + 16'd2;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a flag-based behavioural model checked every
// cycle, plus literal expectations along each scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_d = 1'b0, stall_m = 1'b0, branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] instr_f, pc_f;
    logic        stall_f, err_instr_mem;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit_if imem_if ();

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_d       (stall_d),
        .stall_m       (stall_m),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem_if.master),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .stall_f       (stall_f),
        .err_instr_mem (err_instr_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: PC, halted, read-in-flight, discard-pending and held-word flags.
    logic [15:0] m_pc, m_hw;
    bit          m_halted, m_busy, m_discard, m_held, m_he;

    always @(negedge clk) begin
        bit          have, issued, e, dlv;
        logic [15:0] w;
        if (rst) begin
            chk("rst_rd",    {15'd0, imem_if.imem_rd}, 16'd0);
            chk("rst_stall", {15'd0, stall_f}, 16'd1);
            chk("rst_instr", instr_f, 16'h0800);
            chk("rst_err",   {15'd0, err_instr_mem}, 16'd0);
            chk("rst_addr",  imem_if.imem_addr, 16'h0000);
            m_pc = 16'h0000; m_halted = 1'b0; m_busy = 1'b0;
            m_discard = 1'b0; m_held = 1'b0; m_hw = 16'h0000; m_he = 1'b0;
        end else begin
            have = 1'b0; issued = 1'b0; w = 16'h0800; e = 1'b0;
            chk("m_rd", {15'd0, imem_if.imem_rd},
                {15'd0, !m_held && !m_halted && !m_busy});
            if (m_held) begin
                have = 1'b1; w = m_hw; e = m_he;
            end else if (!m_halted && !m_busy && !imem_if.imem_stall) begin
                if (imem_if.imem_done) begin
                    have = 1'b1; w = imem_if.imem_data; e = imem_if.imem_err;
                end else begin
                    issued = 1'b1;
                end
            end else if (!m_halted && m_busy && imem_if.imem_done && !m_discard) begin
                have = 1'b1; w = imem_if.imem_data; e = imem_if.imem_err;
            end
            dlv = have && !branch_taken;
            chk("m_addr",  imem_if.imem_addr, m_pc);
            chk("m_stall", {15'd0, stall_f}, {15'd0, !dlv});
            chk("m_instr", instr_f, dlv ? w : 16'h0800);
            chk("m_err",   {15'd0, err_instr_mem}, {15'd0, dlv && e});
            if (dlv) chk("m_pcf", pc_f, m_pc + 16'd2);
            if (branch_taken) begin
                m_busy    = (m_busy && !imem_if.imem_done) || issued;
                m_discard = m_busy;
                m_pc      = branch_target;
                m_held    = 1'b0;
                m_halted  = 1'b0;
            end else begin
                if (m_busy && imem_if.imem_done) begin
                    m_busy = 1'b0; m_discard = 1'b0;
                end
                if (issued) m_busy = 1'b1;
                if (have && !stall_d && !stall_m) begin
                    m_pc     = m_pc + 16'd2;
                    m_held   = 1'b0;
                    m_halted = (w[15:11] == 5'b00000) || e;
                end else if (have) begin
                    m_held = 1'b1; m_hw = w; m_he = e;
                end
            end
        end
    end

    // One cycle: drive after the rising edge, return at the falling edge.
    task automatic cyc(input logic r, input logic sd, input logic sm, input logic br,
                       input logic [15:0] tgt, input logic ist, input logic dn,
                       input logic [15:0] dat, input logic er);
        @(posedge clk);
        #1;
        rst = r; stall_d = sd; stall_m = sm; branch_taken = br; branch_target = tgt;
        imem_if.imem_stall = ist; imem_if.imem_done = dn;
        imem_if.imem_data = dat; imem_if.imem_err = er;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic done_w(input logic [15:0] dat);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, dat, 1'b0);
    endtask

    initial begin
        imem_if.imem_stall = 1'b0; imem_if.imem_done = 1'b0;
        imem_if.imem_data  = 16'h0000; imem_if.imem_err = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234, 1'b0);

        // zero-wait memory
        done_w(16'h1000);
        chk("zw_instr0", instr_f, 16'h1000);
        chk("zw_pcf0", pc_f, 16'h0002);
        done_w(16'h1002);
        chk("zw_pcf1", pc_f, 16'h0004);
        done_w(16'h1004);
        chk("zw_pcf2", pc_f, 16'h0006);
        chk("zw_stall2", {15'd0, stall_f}, 16'd0);

        // three-cycle latency
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("lat_stall", {15'd0, stall_f}, 16'd1);
            chk("lat_nop", instr_f, 16'h0800);
        end
        done_w(16'h2000);
        chk("lat_pcf", pc_f, 16'h0008);
        done_w(16'h2002);
        chk("lat_next_addr", imem_if.imem_addr, 16'h0008);

        // decode stall held for two cycles at delivery
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h3000, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("hold_instr1", instr_f, 16'h3000);
        chk("hold_rd", {15'd0, imem_if.imem_rd}, 16'd0);
        idle();
        chk("hold_instr2", instr_f, 16'h3000);
        chk("hold_pcf", pc_f, 16'h000C);
        idle();
        chk("hold_reissue", imem_if.imem_addr, 16'h000C);
        done_w(16'h3002);
        chk("hold_after", pc_f, 16'h000E);

        // redirect while a read is in flight
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 1'b0);
        done_w(16'hDEAD);
        chk("br_drop", instr_f, 16'h0800);
        idle();
        chk("br_addr", imem_if.imem_addr, 16'h0040);
        done_w(16'h4000);
        chk("br_pcf", pc_f, 16'h0042);

        // HALT word then resume by redirect
        done_w(16'h0000);
        chk("halt_dlv", {15'd0, stall_f}, 16'd0);
        idle();
        chk("halt_rd", {15'd0, imem_if.imem_rd}, 16'd0);
        done_w(16'h5555);
        chk("halt_ign", {15'd0, stall_f}, 16'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 1'b0);
        done_w(16'h5000);
        chk("resume_pcf", pc_f, 16'h0012);

        // memory error, then reset during a read
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h6000, 1'b1);
        chk("err_flag", {15'd0, err_instr_mem}, 16'd1);
        idle();
        chk("err_halt", {15'd0, imem_if.imem_rd}, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 1'b0);
        idle();
        idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("rst_mid_pc", imem_if.imem_addr, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF, 1'b0);

        // memory back-pressure, decode stall without a word
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h9999, 1'b0);
        chk("istall_nodlv", {15'd0, stall_f}, 16'd1);
        done_w(16'h7000);
        chk("istall_pcf", pc_f, 16'h0002);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        done_w(16'h7002);
        chk("sd_noword", pc_f, 16'h0004);

        // memory-stage stall, redirect from HOLD, PC wrap
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h8000, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("hold_br", {15'd0, stall_f}, 16'd1);
        done_w(16'h1234);
        chk("wrap_pcf", pc_f, 16'h0000);
        done_w(16'h1236);
        chk("wrap_addr", imem_if.imem_addr, 16'h0000);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
